// File: rtl/dir_pkg.sv
// Shared encodings for the home-node directory: entry states, request and
// message codes, sequencer FSM states and the directory entry layout.
package dir_pkg;

  localparam logic [1:0] INVALID  = 2'b01;
  localparam logic [1:0] SHARED   = 2'b10;
  localparam logic [1:0] MODIFIED = 2'b11;

  localparam logic [1:0] NONE       = 2'b00;
  localparam logic [1:0] READ_MISS  = 2'b01;
  localparam logic [1:0] WRITE_MISS = 2'b10;
  localparam logic [1:0] WRITE_BACK = 2'b11;

  localparam logic [1:0] MSG_INV       = 2'b01;
  localparam logic [1:0] MSG_FETCH     = 2'b10;
  localparam logic [1:0] MSG_FETCH_INV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND_MSG,
    WAIT_ACK,
    REPLY
  } fsm_state_e;

  typedef struct packed {
    logic [1:0] state;
    logic [1:0] sharers;
  } entry_t;

  function automatic logic [1:0] node_mask(input logic node);
    return node ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/directory_entry_array.sv
// Directory storage: one entry per block, a lookup read port, a probe read
// port and a single synchronous write port.
module directory_entry_array import dir_pkg::*; #(
  parameter int NUM_BLOCKS = 4,
  localparam int IDX_W = $clog2(NUM_BLOCKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output entry_t           rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  entry_t           wr_entry,
  input  logic [IDX_W-1:0] probe_idx,
  output entry_t           probe_entry
);

  entry_t entries_q [NUM_BLOCKS];
  entry_t entries_d [NUM_BLOCKS];

  always_comb begin
    entries_d = entries_q;
    if (wr_en) entries_d[wr_idx] = wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) entries_q[i] <= {INVALID, 2'b00};
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_entry    = entries_q[rd_idx];
  assign probe_entry = entries_q[probe_idx];

endmodule

// File: rtl/directory_request_sequencer.sv
// Home-node directory controller: serialises cache miss/write-back requests,
// issues fetch/invalidate messages to remote holders and replies with a grant.
module directory_request_sequencer import dir_pkg::*; #(
  parameter int NUM_BLOCKS = 4,
  localparam int IDX_W = $clog2(NUM_BLOCKS)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqNode,
  input  logic [IDX_W-1:0] reqBlock,
  input  logic [1:0]       reqType,
  output logic             msgValid,
  input  logic             msgReady,
  output logic             msgNode,
  output logic [1:0]       msgKind,
  input  logic             ackValid,
  input  logic             ackNode,
  output logic             replyValid,
  input  logic             replyReady,
  output logic             replyNode,
  output logic [IDX_W-1:0] replyBlock,
  output logic [1:0]       replyState,
  input  logic [IDX_W-1:0] probeBlock,
  output logic [1:0]       probeState,
  output logic [1:0]       probeSharers
);

  fsm_state_e       state_q, state_d;
  logic             req_node_q, req_node_d;
  logic [IDX_W-1:0] req_block_q, req_block_d;
  logic [1:0]       req_type_q, req_type_d;
  logic             msg_valid_q, msg_valid_d;
  logic             msg_node_q, msg_node_d;
  logic [1:0]       msg_kind_q, msg_kind_d;
  logic             reply_valid_q, reply_valid_d;
  logic             reply_node_q, reply_node_d;
  logic [IDX_W-1:0] reply_block_q, reply_block_d;
  logic [1:0]       reply_state_q, reply_state_d;

  entry_t     cur_entry, probe_entry, wr_entry;
  logic       wr_en;
  logic [1:0] req_mask, other_mask;
  logic       owner_is_req;

  directory_entry_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_entries (
    .clk        (clock),
    .rst_n      (resetN),
    .rd_idx     (req_block_q),
    .rd_entry   (cur_entry),
    .wr_en      (wr_en),
    .wr_idx     (req_block_q),
    .wr_entry   (wr_entry),
    .probe_idx  (probeBlock),
    .probe_entry(probe_entry)
  );

  assign req_mask     = node_mask(req_node_q);
  assign other_mask   = cur_entry.sharers & ~req_mask;
  assign owner_is_req = |(cur_entry.sharers & req_mask);

  // The entry is only written on the LOOKUP edge or the accepted-ack edge.
  always_comb begin
    state_d       = state_q;
    req_node_d    = req_node_q;
    req_block_d   = req_block_q;
    req_type_d    = req_type_q;
    msg_valid_d   = msg_valid_q;
    msg_node_d    = msg_node_q;
    msg_kind_d    = msg_kind_q;
    reply_valid_d = reply_valid_q;
    reply_node_d  = reply_node_q;
    reply_block_d = reply_block_q;
    reply_state_d = reply_state_q;
    wr_en         = 1'b0;
    wr_entry      = cur_entry;

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          req_node_d  = reqNode;
          req_block_d = reqBlock;
          req_type_d  = reqType;
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        state_d       = REPLY;
        reply_valid_d = 1'b1;
        reply_node_d  = req_node_q;
        reply_block_d = req_block_q;
        case (req_type_q)
          READ_MISS: begin
            reply_state_d = SHARED;
            if (cur_entry.state == MODIFIED && !owner_is_req) begin
              reply_valid_d = 1'b0;
              msg_valid_d   = 1'b1;
              msg_node_d    = cur_entry.sharers[1];
              msg_kind_d    = MSG_FETCH;
              state_d       = SEND_MSG;
            end else begin
              wr_en    = 1'b1;
              wr_entry = {SHARED, cur_entry.sharers | req_mask};
            end
          end
          WRITE_MISS: begin
            reply_state_d = MODIFIED;
            if (other_mask != 2'b00) begin
              reply_valid_d = 1'b0;
              msg_valid_d   = 1'b1;
              msg_node_d    = ~req_node_q;
              msg_kind_d    = (cur_entry.state == MODIFIED) ? MSG_FETCH_INV : MSG_INV;
              state_d       = SEND_MSG;
            end else begin
              wr_en    = 1'b1;
              wr_entry = {MODIFIED, req_mask};
            end
          end
          WRITE_BACK: begin
            reply_valid_d = 1'b0;
            state_d       = IDLE;
            if (cur_entry.state == MODIFIED && owner_is_req) begin
              wr_en    = 1'b1;
              wr_entry = {INVALID, 2'b00};
            end
          end
          NONE: begin
            reply_valid_d = 1'b0;
            state_d       = IDLE;
          end
        endcase
      end

      SEND_MSG: begin
        if (msgReady) begin
          msg_valid_d = 1'b0;
          state_d     = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (ackValid && ackNode == msg_node_q) begin
          wr_en         = 1'b1;
          reply_valid_d = 1'b1;
          reply_node_d  = req_node_q;
          reply_block_d = req_block_q;
          state_d       = REPLY;
          if (msg_kind_q == MSG_FETCH) begin
            wr_entry      = {SHARED, cur_entry.sharers | req_mask};
            reply_state_d = SHARED;
          end else begin
            wr_entry      = {MODIFIED, req_mask};
            reply_state_d = MODIFIED;
          end
        end
      end

      REPLY: begin
        if (replyReady) begin
          reply_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      req_node_q    <= 1'b0;
      req_block_q   <= '0;
      req_type_q    <= NONE;
      msg_valid_q   <= 1'b0;
      msg_node_q    <= 1'b0;
      msg_kind_q    <= 2'b00;
      reply_valid_q <= 1'b0;
      reply_node_q  <= 1'b0;
      reply_block_q <= '0;
      reply_state_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      req_node_q    <= req_node_d;
      req_block_q   <= req_block_d;
      req_type_q    <= req_type_d;
      msg_valid_q   <= msg_valid_d;
      msg_node_q    <= msg_node_d;
      msg_kind_q    <= msg_kind_d;
      reply_valid_q <= reply_valid_d;
      reply_node_q  <= reply_node_d;
      reply_block_q <= reply_block_d;
      reply_state_q <= reply_state_d;
    end
  end

  assign reqReady     = (state_q == IDLE);
  assign msgValid     = msg_valid_q;
  assign msgNode      = msg_node_q;
  assign msgKind      = msg_kind_q;
  assign replyValid   = reply_valid_q;
  assign replyNode    = reply_node_q;
  assign replyBlock   = reply_block_q;
  assign replyState   = reply_state_q;
  assign probeState   = probe_entry.state;
  assign probeSharers = probe_entry.sharers;

endmodule
